// File: rtl/spi_i2s_dma_if.sv
// Signal bundle between the SPI/I2S data-register/FIFO side, the DMA engine and spi_i2s_dma_req.
// tx_state/rx_state expose each channel FSM (0 IDLE, 1 WAIT, 2 REQ, 3 BURST, 4 HOLD, 5 DONE).
interface spi_i2s_dma_if #(
  parameter int LEN_W = 16
);
  logic             tx_en;
  logic             rx_en;
  logic [3:0]       tx_burst;
  logic [3:0]       rx_burst;
  logic [LEN_W-1:0] tx_len;
  logic [LEN_W-1:0] rx_len;
  logic [3:0]       tx_fifo_space;
  logic [3:0]       rx_fifo_fill;
  logic             dr_wr;
  logic             dr_rd;
  logic             dma_tx_ack;
  logic             dma_rx_ack;
  logic             dma_tx_req;
  logic             dma_rx_req;
  logic             dma_tx_last;
  logic             dma_rx_last;
  logic             tx_done;
  logic             rx_done;
  logic [LEN_W-1:0] tx_remain;
  logic [LEN_W-1:0] rx_remain;
  logic [2:0]       tx_state;
  logic [2:0]       rx_state;

  // Handshake: dma_*_req stays high until the DMA engine returns a one-cycle dma_*_ack; req
  // drops on the edge that samples the ack, and the burst's beats then arrive as dr_wr/dr_rd strobes.
  modport slave (
    input  tx_en, rx_en, tx_burst, rx_burst, tx_len, rx_len, tx_fifo_space, rx_fifo_fill,
    input  dr_wr, dr_rd, dma_tx_ack, dma_rx_ack,
    output dma_tx_req, dma_rx_req, dma_tx_last, dma_rx_last, tx_done, rx_done,
    output tx_remain, rx_remain, tx_state, rx_state
  );

  modport master (
    output tx_en, rx_en, tx_burst, rx_burst, tx_len, rx_len, tx_fifo_space, rx_fifo_fill,
    output dr_wr, dr_rd, dma_tx_ack, dma_rx_ack,
    input  dma_tx_req, dma_rx_req, dma_tx_last, dma_rx_last, tx_done, rx_done,
    input  tx_remain, rx_remain, tx_state, rx_state
  );
endinterface

// File: rtl/spi_i2s_dma_req.sv
// DMA request generator for the SPI/I2S peripheral: two identical burst-request channels.
// Define SPI_I2S_DMA_LEN_EN for length counting (last/remain/done); otherwise channels stream forever.
module spi_i2s_dma_chan #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [3:0]       burst_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [3:0]       level_i,
  input  logic             strobe_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic             last_o,
  output logic             done_o,
  output logic [LEN_W-1:0] remain_o,
  output logic [2:0]       state_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REQ   = 3'd2,
    S_BURST = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  state_e     state_q;
  logic       en_q;
  logic [3:0] beat_q;
  logic       req_q;
  logic       last_q;
  logic       done_q;
  logic [3:0] burst_c;
  logic [3:0] eff;

  always_comb begin
    burst_c = burst_i;
    if (burst_i == 4'd0) begin
      burst_c = 4'd1;
    end else if ({1'b0, burst_i} > DEPTH_C) begin
      burst_c = DEPTH_C[3:0];
    end
  end

`ifdef SPI_I2S_DMA_LEN_EN
  logic [LEN_W-1:0] remain_q;
  logic             is_last;

  // The final burst shrinks to whatever is left of the transfer.
  assign eff      = (remain_q < LEN_W'(burst_c)) ? remain_q[3:0] : burst_c;
  assign is_last  = (remain_q <= LEN_W'(burst_c));
  assign remain_o = remain_q;
`else
  logic unused_len;

  assign eff        = burst_c;
  assign remain_o   = '0;
  assign unused_len = ^len_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      beat_q   <= 4'd0;
      req_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SPI_I2S_DMA_LEN_EN
      remain_q <= '0;
`endif
    end else begin
      en_q   <= en_i;
      done_q <= 1'b0;
      if (!en_i) begin
        // Dropping the enable aborts from any state; remain keeps its value for software.
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!en_q) begin
`ifdef SPI_I2S_DMA_LEN_EN
              remain_q <= len_i;
              if (len_i == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WAIT;
              end
`else
              state_q <= S_WAIT;
`endif
            end
          end
          S_WAIT: begin
            if (level_i >= eff) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
`ifdef SPI_I2S_DMA_LEN_EN
              last_q  <= is_last;
`endif
            end
          end
          S_REQ: begin
            if (ack_i) begin
              state_q <= S_BURST;
              beat_q  <= eff;
              req_q   <= 1'b0;
              last_q  <= 1'b0;
            end
          end
          S_BURST: begin
            if (strobe_i) begin
              beat_q <= beat_q - 4'd1;
`ifdef SPI_I2S_DMA_LEN_EN
              if (remain_q != '0) begin
                remain_q <= remain_q - LEN_W'(1);
              end
`endif
              if (beat_q == 4'd1) begin
                state_q <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            // One idle cycle lets the FIFO level reflect the finished burst.
`ifdef SPI_I2S_DMA_LEN_EN
            if (remain_q == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
`else
            state_q <= S_WAIT;
`endif
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign req_o   = req_q;
  assign last_o  = last_q;
  assign done_o  = done_q;
  assign state_o = state_q;
endmodule

module spi_i2s_dma_req #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic          pclk,
  input logic          rst,
  spi_i2s_dma_if.slave bus
);
  spi_i2s_dma_chan #(.LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk_i    (pclk),
    .rst_i    (rst),
    .en_i     (bus.tx_en),
    .burst_i  (bus.tx_burst),
    .len_i    (bus.tx_len),
    .level_i  (bus.tx_fifo_space),
    .strobe_i (bus.dr_wr),
    .ack_i    (bus.dma_tx_ack),
    .req_o    (bus.dma_tx_req),
    .last_o   (bus.dma_tx_last),
    .done_o   (bus.tx_done),
    .remain_o (bus.tx_remain),
    .state_o  (bus.tx_state)
  );

  spi_i2s_dma_chan #(.LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
    .clk_i    (pclk),
    .rst_i    (rst),
    .en_i     (bus.rx_en),
    .burst_i  (bus.rx_burst),
    .len_i    (bus.rx_len),
    .level_i  (bus.rx_fifo_fill),
    .strobe_i (bus.dr_rd),
    .ack_i    (bus.dma_rx_ack),
    .req_o    (bus.dma_rx_req),
    .last_o   (bus.dma_rx_last),
    .done_o   (bus.rx_done),
    .remain_o (bus.rx_remain),
    .state_o  (bus.rx_state)
  );
endmodule

// File: tb/tb_spi_i2s_dma_req.sv
// Self-checking bench for spi_i2s_dma_req; expectations follow SPI_I2S_DMA_LEN_EN when defined.
module tb_spi_i2s_dma_req;
  localparam int LEN_W = 16;
  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_REQ = 2, ST_BURST = 3, ST_HOLD = 4, ST_DONE = 5;
`ifdef SPI_I2S_DMA_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] burst;
    logic [3:0] level;
    logic       exp_req;
    logic [4:0] exp_beats;
  } vec_t;

  // clock / reset
  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  spi_i2s_dma_if #(.LEN_W(LEN_W)) bus ();

  spi_i2s_dma_req #(.LEN_W(LEN_W), .FIFO_DEPTH(8)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int exp_tx_done = 0;
  int exp_rx_done = 0;
  logic [LEN_W:0] exp_tx_q[$];
  logic [LEN_W:0] exp_rx_q[$];
  logic tx_req_prev = 1'b0;
  logic rx_req_prev = 1'b0;
  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic int st(input bit rx);
    return rx ? int'(bus.rx_state) : int'(bus.tx_state);
  endfunction
  function automatic int rq(input bit rx);
    return rx ? int'(bus.dma_rx_req) : int'(bus.dma_tx_req);
  endfunction
  function automatic int rem(input bit rx);
    return rx ? int'(bus.rx_remain) : int'(bus.tx_remain);
  endfunction
  function automatic int dn(input bit rx);
    return rx ? int'(bus.rx_done) : int'(bus.tx_done);
  endfunction
  function automatic int outs_word();
    return int'({bus.dma_tx_req, bus.dma_tx_last, bus.tx_done,
                 bus.dma_rx_req, bus.dma_rx_last, bus.rx_done})
           | int'(bus.tx_remain) | int'(bus.rx_remain);
  endfunction

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.tx_en = 1'b0;         bus.rx_en = 1'b0;
    bus.tx_burst = 4'd0;      bus.rx_burst = 4'd0;
    bus.tx_len = '0;          bus.rx_len = '0;
    bus.tx_fifo_space = 4'd0; bus.rx_fifo_fill = 4'd0;
    bus.dr_wr = 1'b0;         bus.dr_rd = 1'b0;
    bus.dma_tx_ack = 1'b0;    bus.dma_rx_ack = 1'b0;
  endtask

  task automatic set_en(input bit rx, input logic v);
    if (rx) bus.rx_en = v; else bus.tx_en = v;
  endtask
  task automatic set_burst(input bit rx, input logic [3:0] v);
    if (rx) bus.rx_burst = v; else bus.tx_burst = v;
  endtask
  task automatic set_len(input bit rx, input logic [LEN_W-1:0] v);
    if (rx) bus.rx_len = v; else bus.tx_len = v;
  endtask
  task automatic set_level(input bit rx, input logic [3:0] v);
    if (rx) bus.rx_fifo_fill = v; else bus.tx_fifo_space = v;
  endtask

  task automatic pulse_ack(input bit rx);
    if (rx) bus.dma_rx_ack = 1'b1; else bus.dma_tx_ack = 1'b1;
    tick(1);
    bus.dma_rx_ack = 1'b0;
    bus.dma_tx_ack = 1'b0;
  endtask

  task automatic pulse_strobe(input bit rx);
    if (rx) bus.dr_rd = 1'b1; else bus.dr_wr = 1'b1;
    tick(1);
    bus.dr_rd = 1'b0;
    bus.dr_wr = 1'b0;
  endtask

  // Strobes one beat per cycle until the channel reaches HOLD; returns the beats spent.
  task automatic count_beats(input bit rx, input int max_n, output int n);
    n = 0;
    for (int i = 0; i < max_n; i++) begin
      pulse_strobe(rx);
      n++;
      if (st(rx) == ST_HOLD) break;
    end
  endtask

  // scoreboard: one {last, remain} record per expected request
  task automatic push_exp(input bit rx, input logic last, input logic [LEN_W-1:0] rem_v);
    logic [LEN_W:0] e;
    e = LEN_EN ? {last, rem_v} : '0;
    if (rx) exp_rx_q.push_back(e); else exp_tx_q.push_back(e);
  endtask

  task automatic sb_pop(input bit rx, input logic [LEN_W:0] act);
    logic [LEN_W:0] e;
    int sz;
    checks++;
    sz = rx ? exp_rx_q.size() : exp_tx_q.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL %s_req_unexpected act=%0h exp=none", rx ? "rx" : "tx", act);
    end else begin
      if (rx) e = exp_rx_q.pop_front(); else e = exp_tx_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL %s_req_last_remain act=%0h exp=%0h", rx ? "rx" : "tx", act, e);
      end
    end
  endtask

  always @(negedge pclk) begin
    if (bus.dma_tx_req && !tx_req_prev) sb_pop(1'b0, {bus.dma_tx_last, bus.tx_remain});
    if (bus.dma_rx_req && !rx_req_prev) sb_pop(1'b1, {bus.dma_rx_last, bus.rx_remain});
    if (bus.tx_done) tx_done_cnt++;
    if (bus.rx_done) rx_done_cnt++;
    tx_req_prev = bus.dma_tx_req;
    rx_req_prev = bus.dma_rx_req;
  end

  task automatic run_vec(input bit rx, input vec_t v);
    bit seen;
    int n;
    set_burst(rx, v.burst);
    set_len(rx, 16'd100);
    set_level(rx, v.level);
    if (v.exp_req) push_exp(rx, 1'b0, 16'd100);
    set_en(rx, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      tick(1);
      seen = (rq(rx) == 1);
    end
    chk($sformatf("%s_vec_req_b%0d_l%0d", rx ? "rx" : "tx", v.burst, v.level), int'(seen), int'(v.exp_req));
    if (seen) begin
      pulse_ack(rx);
      chk("vec_ack_burst", st(rx), ST_BURST);
      count_beats(rx, 16, n);
      chk($sformatf("%s_vec_beats_b%0d", rx ? "rx" : "tx", v.burst), n, int'(v.exp_beats));
    end
    set_en(rx, 1'b0);
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // burst, level, request expected, beats per burst (FIFO_DEPTH = 8)
    vecs[0] = '{4'd4,  4'd8,  1'b1, 5'd4};
    vecs[1] = '{4'd4,  4'd3,  1'b0, 5'd0};
    vecs[2] = '{4'd15, 4'd8,  1'b1, 5'd8};
    vecs[3] = '{4'd15, 4'd7,  1'b0, 5'd0};
    vecs[4] = '{4'd0,  4'd1,  1'b1, 5'd1};
    vecs[5] = '{4'd0,  4'd0,  1'b0, 5'd0};
    vecs[6] = '{4'd9,  4'd8,  1'b1, 5'd8};
    vecs[7] = '{4'd8,  4'd15, 1'b1, 5'd8};
    vecs[8] = '{4'd1,  4'd1,  1'b1, 5'd1};

    idle_inputs();
    rst = 1'b1;
    tick(2);
    chk("rst_outputs", outs_word(), 0);
    chk("rst_tx_state", st(1'b0), ST_IDLE);
    chk("rst_rx_state", st(1'b1), ST_IDLE);
    rst = 1'b0;
    tick(1);

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 9; i++) run_vec(c == 1, vecs[i]);
    end

    // enable-rise timing, ack with simultaneous strobe, inter-burst gap
    set_burst(1'b0, 4'd4);
    set_len(1'b0, 16'd8);
    set_level(1'b0, 4'($urandom_range(15, 8)));
    push_exp(1'b0, 1'b0, 16'd8);
    set_en(1'b0, 1'b1);
    tick(1);
    chk("rise_wait", st(1'b0), ST_WAIT);
    chk("rise_req_low", rq(1'b0), 0);
    tick(1);
    chk("rise_req_n2", rq(1'b0), 1);
    bus.dma_tx_ack = 1'b1;
    bus.dr_wr = 1'b1;
    tick(1);
    bus.dma_tx_ack = 1'b0;
    bus.dr_wr = 1'b0;
    chk("ack_req_drop", rq(1'b0), 0);
    chk("ack_burst", st(1'b0), ST_BURST);
    count_beats(1'b0, 16, n);
    chk("ack_strobe_beats", n, 4);
    chk("remain_after_b1", rem(1'b0), LEN_EN ? 4 : 0);
    push_exp(1'b0, 1'b1, 16'd4);
    tick(1);
    chk("hold_to_wait", st(1'b0), ST_WAIT);
    chk("gap_req_low", rq(1'b0), 0);
    tick(1);
    chk("gap_req_k2", rq(1'b0), 1);
    pulse_ack(1'b0);
    count_beats(1'b0, 16, n);
    chk("b2_beats", n, 4);
`ifdef SPI_I2S_DMA_LEN_EN
    chk("remain_after_b2", rem(1'b0), 0);
    tick(1);
    chk("done_state", st(1'b0), ST_DONE);
    chk("done_pulse", dn(1'b0), 1);
    exp_tx_done++;
    tick(1);
    chk("done_clear", dn(1'b0), 0);
    chk("done_to_idle", st(1'b0), ST_IDLE);
    tick(3);
    chk("no_restart", st(1'b0), ST_IDLE);
`else
    push_exp(1'b0, 1'b0, 16'd0);
    tick(2);
    chk("stream_req3", rq(1'b0), 1);
    chk("stream_last", int'(bus.dma_tx_last), 0);
    pulse_ack(1'b0);
    count_beats(1'b0, 16, n);
    chk("stream_b3_beats", n, 4);
    tick(1);
    chk("stream_back_to_wait", st(1'b0), ST_WAIT);
    chk("stream_done_low", dn(1'b0), 0);
    chk("stream_remain_zero", rem(1'b0), 0);
`endif
    set_en(1'b0, 1'b0);
    tick(2);

    // stray strobes and ack in WAIT, then ack together with enable falling
    set_level(1'b0, 4'd2);
    set_en(1'b0, 1'b1);
    tick(2);
    chk("stray_wait", st(1'b0), ST_WAIT);
    pulse_strobe(1'b0);
    pulse_strobe(1'b0);
    pulse_ack(1'b0);
    chk("stray_still_wait", st(1'b0), ST_WAIT);
    chk("stray_req_low", rq(1'b0), 0);
    chk("stray_remain", rem(1'b0), LEN_EN ? 8 : 0);
    push_exp(1'b0, 1'b0, 16'd8);
    set_level(1'b0, 4'd4);
    tick(1);
    chk("level_rise_req", rq(1'b0), 1);
    bus.dma_tx_ack = 1'b1;
    bus.tx_en = 1'b0;
    tick(1);
    bus.dma_tx_ack = 1'b0;
    chk("ack_en_fall_idle", st(1'b0), ST_IDLE);
    chk("ack_en_fall_req", rq(1'b0), 0);
    tick(1);
    chk("ack_en_fall_stays", st(1'b0), ST_IDLE);

    // abort after 2 of 4 beats
    set_level(1'b0, 4'd8);
    push_exp(1'b0, 1'b0, 16'd8);
    set_en(1'b0, 1'b1);
    tick(2);
    chk("abort_req", rq(1'b0), 1);
    pulse_ack(1'b0);
    pulse_strobe(1'b0);
    pulse_strobe(1'b0);
    chk("abort_mid_burst", st(1'b0), ST_BURST);
    set_en(1'b0, 1'b0);
    tick(1);
    chk("abort_idle", st(1'b0), ST_IDLE);
    chk("abort_req_low", rq(1'b0), 0);
    chk("abort_remain", rem(1'b0), LEN_EN ? 6 : 0);
    pulse_strobe(1'b0);
    pulse_strobe(1'b0);
    chk("abort_remain_hold", rem(1'b0), LEN_EN ? 6 : 0);
    chk("abort_state_hold", st(1'b0), ST_IDLE);

    // asynchronous reset in the middle of an RX burst
    set_burst(1'b1, 4'd4);
    set_len(1'b1, 16'd8);
    set_level(1'b1, 4'd8);
    push_exp(1'b1, 1'b0, 16'd8);
    set_en(1'b1, 1'b1);
    tick(2);
    chk("rst_seq_req", rq(1'b1), 1);
    pulse_ack(1'b1);
    pulse_strobe(1'b1);
    chk("rst_seq_remain", rem(1'b1), LEN_EN ? 7 : 0);
    #2;
    rst = 1'b1;
    bus.rx_en = 1'b0;
    #1;
    chk("async_rst_outs", outs_word(), 0);
    chk("async_rst_state", st(1'b1), ST_IDLE);
    tick(1);
    rst = 1'b0;
    tick(1);

`ifdef SPI_I2S_DMA_LEN_EN
    // zero-length transfer
    set_len(1'b0, 16'd0);
    set_en(1'b0, 1'b1);
    tick(1);
    chk("len0_done_state", st(1'b0), ST_DONE);
    chk("len0_done", dn(1'b0), 1);
    exp_tx_done++;
    tick(1);
    chk("len0_done_clear", dn(1'b0), 0);
    chk("len0_idle", st(1'b0), ST_IDLE);
    set_en(1'b0, 1'b0);
    tick(2);

    // RX threshold: 5 beats as a 4-beat burst then a 1-beat last burst
    set_burst(1'b1, 4'd4);
    set_len(1'b1, 16'd5);
    set_level(1'b1, 4'd3);
    set_en(1'b1, 1'b1);
    tick(4);
    chk("rx_thr_wait", st(1'b1), ST_WAIT);
    chk("rx_thr_noreq", rq(1'b1), 0);
    push_exp(1'b1, 1'b0, 16'd5);
    set_level(1'b1, 4'd4);
    tick(1);
    chk("rx_thr_req", rq(1'b1), 1);
    pulse_ack(1'b1);
    count_beats(1'b1, 16, n);
    chk("rx_thr_beats", n, 4);
    chk("rx_thr_remain", rem(1'b1), 1);
    set_level(1'b1, 4'd0);
    tick(3);
    chk("rx_tail_wait", rq(1'b1), 0);
    push_exp(1'b1, 1'b1, 16'd1);
    set_level(1'b1, 4'd1);
    tick(1);
    chk("rx_tail_req", rq(1'b1), 1);
    pulse_ack(1'b1);
    count_beats(1'b1, 16, n);
    chk("rx_tail_beats", n, 1);
    tick(1);
    chk("rx_done", dn(1'b1), 1);
    exp_rx_done++;
    set_en(1'b1, 1'b0);
    tick(2);
`endif

    chk("tx_done_count", tx_done_cnt, exp_tx_done);
    chk("rx_done_count", rx_done_cnt, exp_rx_done);
    chk("tx_sb_empty", exp_tx_q.size(), 0);
    chk("rx_sb_empty", exp_rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
